// File: rtl/uart_tx_slave.sv
// uart_tx_slave: bus-mapped 8N1 UART transmitter with a TX FIFO,
// programmable baud divisor and a level interrupt on FIFO drain.
module uart_tx_slave #(
    parameter int CLK_DIV    = 434,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_we,
    input  logic [31:0] uart_adr,
    input  logic [31:0] uart_wdata,
    output logic [31:0] uart_rdata,
    output logic        int_sig_o,
    output logic        tx_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [15:0]   DIV_RST = 16'(CLK_DIV);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic          tx_en;
    logic          int_en;
    logic [15:0]   baud;
    logic [15:0]   div_q;
    logic [15:0]   tmr;
    logic [7:0]    shreg;
    logic [2:0]    bit_idx;

    logic sel_tx, sel_st, sel_ctrl, sel_baud;
    logic empty, full, busy, tmr_done;
    logic push, pop;

    assign sel_tx   = uart_we && (uart_adr[3:2] == 2'd0);
    assign sel_st   = uart_we && (uart_adr[3:2] == 2'd1);
    assign sel_ctrl = uart_we && (uart_adr[3:2] == 2'd2);
    assign sel_baud = uart_we && (uart_adr[3:2] == 2'd3);

    assign empty    = (count == '0);
    assign full     = (count == DEPTH_C);
    assign busy     = (state != IDLE);
    assign tmr_done = (tmr == 16'd0);

    // A pop happens on any edge that launches a frame
    assign pop  = tx_en && !empty &&
                  ((state == IDLE) || (state == STOP && tmr_done));
    assign push = sel_tx && !full;

    always_comb begin
        uart_rdata = '0;
        unique case (uart_adr[3:2])
            2'd0: uart_rdata = '0;
            2'd1: uart_rdata = {20'd0, 4'(count), 4'd0,
                                overflow, empty, full, busy};
            2'd2: uart_rdata = {30'd0, int_en, tx_en};
            default: uart_rdata = {16'd0, baud};
        endcase
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= uart_wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_en     <= 1'b0;
            int_en    <= 1'b0;
            baud      <= DIV_RST;
            overflow  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            int_sig_o <= 1'b0;
        end else begin
            if (sel_ctrl) begin
                tx_en  <= uart_wdata[0];
                int_en <= uart_wdata[1];
            end
            if (sel_baud) begin
                baud <= (uart_wdata[15:0] == 16'd0) ?
                        16'd1 : uart_wdata[15:0];
            end
            if (sel_tx && full) begin
                overflow <= 1'b1;
            end else if (sel_st && uart_wdata[3]) begin
                overflow <= 1'b0;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            int_sig_o <= int_en && empty && !busy;
        end
    end

    // Divisor is latched at frame launch so BAUD writes only hit the next frame
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tx_o    <= 1'b1;
            div_q   <= DIV_RST;
            tmr     <= '0;
            shreg   <= '0;
            bit_idx <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    tx_o <= 1'b1;
                    if (pop) begin
                        state <= START;
                        tx_o  <= 1'b0;
                        shreg <= mem[rd_ptr];
                        div_q <= baud;
                        tmr   <= baud - 16'd1;
                    end
                end
                START: begin
                    if (tmr_done) begin
                        state   <= DATA;
                        tx_o    <= shreg[0];
                        tmr     <= div_q - 16'd1;
                        bit_idx <= '0;
                    end else begin
                        tmr <= tmr - 16'd1;
                    end
                end
                DATA: begin
                    if (tmr_done) begin
                        tmr <= div_q - 16'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx_o  <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx_o    <= shreg[1];
                        end
                    end else begin
                        tmr <= tmr - 16'd1;
                    end
                end
                STOP: begin
                    if (tmr_done) begin
                        if (pop) begin
                            state <= START;
                            tx_o  <= 1'b0;
                            shreg <= mem[rd_ptr];
                            div_q <= baud;
                            tmr   <= baud - 16'd1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        tmr <= tmr - 16'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_slave.sv
// tb_uart_tx_slave: directed + randomized bench for uart_tx_slave,
// line level predicted from frame arithmetic per bit time.
module tb_uart_tx_slave;
    localparam int DEPTH   = 4;
    localparam int RST_DIV = 16;
    localparam logic [1:0] A_TX   = 2'd0;
    localparam logic [1:0] A_ST   = 2'd1;
    localparam logic [1:0] A_CTRL = 2'd2;
    localparam logic [1:0] A_BAUD = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        uart_we;
    logic [31:0] uart_adr;
    logic [31:0] uart_wdata;
    logic [31:0] uart_rdata;
    logic        int_sig_o;
    logic        tx_o;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_b[$];
    int         exp_d[$];
    logic [7:0] mq[$];
    logic       movf;

    always #5 clk = ~clk;

    uart_tx_slave #(.CLK_DIV(RST_DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .uart_we(uart_we), .uart_adr(uart_adr),
        .uart_wdata(uart_wdata), .uart_rdata(uart_rdata),
        .int_sig_o(int_sig_o), .tx_o(tx_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Caller is in the low phase; the write is sampled at the next edge
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        uart_we    = 1'b1;
        uart_adr   = {28'h0, a, 2'b00};
        uart_wdata = d;
        @(negedge clk);
        uart_we    = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] v);
        uart_adr = {28'h0, a, 2'b00};
        #1;
        v = uart_rdata;
    endtask

    function automatic logic [31:0] stat(input int cnt, input logic ovf,
                                         input logic bsy);
        logic [31:0] v;
        v = 32'(cnt) << 8;
        v[3] = ovf;
        v[2] = (cnt == 0);
        v[1] = (cnt == DEPTH);
        v[0] = bsy;
        return v;
    endfunction

    // Expected line level n clocks after the first launch edge
    function automatic logic line_at(input int n);
        int off;
        int m;
        int b;
        logic [7:0] byt;
        off = 0;
        for (int i = 0; i < exp_b.size(); i++) begin
            m = n - off;
            if (m < 10 * exp_d[i]) begin
                b = m / exp_d[i];
                byt = exp_b[i];
                if (b == 0) return 1'b0;
                if (b == 9) return 1'b1;
                return byt[b-1];
            end
            off += 10 * exp_d[i];
        end
        return 1'b1;
    endfunction

    task automatic trace(input string tag, input int n0, input logic ie);
        int total;
        logic [31:0] st;
        total = 0;
        foreach (exp_d[i]) total += 10 * exp_d[i];
        uart_adr = {28'h0, A_ST, 2'b00};
        for (int n = n0; n < total + 3; n++) begin
            @(negedge clk);
            #1;
            st = uart_rdata;
            chk({tag, "_tx"}, 32'(tx_o), 32'(line_at(n)));
            chk({tag, "_busy"}, 32'(st[0]), 32'(n < total));
            chk({tag, "_int"}, 32'(int_sig_o), 32'(ie && n >= total + 1));
        end
    endtask

    initial begin
        logic [31:0] v;
        logic [7:0]  b1;
        logic [7:0]  b2;
        int          d;

        rst = 1'b1;
        uart_we = 1'b0;
        uart_adr = '0;
        uart_wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_tx", 32'(tx_o), 32'd1);
        chk("rst_int", 32'(int_sig_o), 32'd0);
        rd(A_ST, v);   chk("rst_status", v, 32'h004);
        rd(A_CTRL, v); chk("rst_ctrl", v, 32'h0);
        rd(A_BAUD, v); chk("rst_baud", v, 32'(RST_DIV));

        // single 0x55 frame at 4 clk/bit
        wr(A_BAUD, 32'd4);
        wr(A_CTRL, 32'd1);
        exp_b = {}; exp_d = {};
        exp_b.push_back(8'h55); exp_d.push_back(4);
        wr(A_TX, 32'h55);
        trace("f55", 0, 1'b0);

        for (int k = 0; k < 3; k++) begin
            d = $urandom_range(5, 1);
            b1 = 8'($urandom);
            wr(A_BAUD, 32'(d));
            exp_b = {}; exp_d = {};
            exp_b.push_back(b1); exp_d.push_back(d);
            wr(A_TX, {24'h0, b1});
            trace("frand", 0, 1'b0);
        end

        // overflow with TX disabled, then drain back-to-back
        wr(A_CTRL, 32'd0);
        wr(A_BAUD, 32'd3);
        mq = {}; movf = 1'b0;
        for (int k = 0; k < 5; k++) begin
            b1 = 8'($urandom);
            if (mq.size() < DEPTH) mq.push_back(b1);
            else movf = 1'b1;
            wr(A_TX, {24'h0, b1});
        end
        rd(A_ST, v); chk("ovf_status", v, stat(mq.size(), movf, 1'b0));
        wr(A_ST, 32'h8);
        rd(A_ST, v); chk("ovf_clear", v, stat(mq.size(), 1'b0, 1'b0));
        exp_b = mq; exp_d = {};
        foreach (mq[i]) exp_d.push_back(3);
        wr(A_CTRL, 32'd1);
        trace("drain", 0, 1'b0);

        // push into a full FIFO on the same edge the FSM pops
        wr(A_CTRL, 32'd0);
        wr(A_BAUD, 32'd2);
        mq = {}; movf = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            b1 = 8'($urandom);
            mq.push_back(b1);
            wr(A_TX, {24'h0, b1});
        end
        rd(A_ST, v); chk("full_status", v, stat(DEPTH, 1'b0, 1'b0));
        exp_b = mq; exp_d = {};
        foreach (mq[i]) exp_d.push_back(2);
        wr(A_CTRL, 32'd1);
        b2 = 8'($urandom);
        if (mq.size() < DEPTH) mq.push_back(b2);
        else movf = 1'b1;
        void'(mq.pop_front());
        wr(A_TX, {24'h0, b2});
        rd(A_ST, v); chk("pushpop_status", v, stat(mq.size(), movf, 1'b1));
        trace("pushpop", 1, 1'b0);
        wr(A_ST, 32'h8);

        // interrupt on drain
        wr(A_BAUD, 32'd2);
        wr(A_CTRL, 32'd3);
        chk("int_lag", 32'(int_sig_o), 32'd0);
        @(negedge clk);
        chk("int_idle", 32'(int_sig_o), 32'd1);
        exp_b = {}; exp_d = {};
        exp_b.push_back(8'hA3); exp_d.push_back(2);
        wr(A_TX, 32'hA3);
        chk("int_push_lag", 32'(int_sig_o), 32'd1);
        trace("intA3", 0, 1'b1);
        b1 = 8'($urandom);
        exp_b = {}; exp_d = {};
        exp_b.push_back(b1); exp_d.push_back(2);
        wr(A_TX, {24'h0, b1});
        chk("int_push2_lag", 32'(int_sig_o), 32'd1);
        trace("int2", 0, 1'b1);

        // reset during DATA bit 3, with a queued byte and a BAUD write
        wr(A_CTRL, 32'd1);
        wr(A_BAUD, 32'd4);
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        wr(A_TX, {24'h0, b1});
        wr(A_TX, {24'h0, b2});
        repeat (17) @(negedge clk);
        chk("pre_rst_bit3", 32'(tx_o), 32'(b1[3]));
        rst = 1'b1;
        uart_we = 1'b1;
        uart_adr = {28'h0, A_BAUD, 2'b00};
        uart_wdata = 32'd7;
        @(negedge clk);
        rst = 1'b0;
        uart_we = 1'b0;
        chk("mid_rst_tx", 32'(tx_o), 32'd1);
        chk("mid_rst_int", 32'(int_sig_o), 32'd0);
        rd(A_ST, v);   chk("mid_rst_status", v, 32'h004);
        rd(A_CTRL, v); chk("mid_rst_ctrl", v, 32'h0);
        rd(A_BAUD, v); chk("mid_rst_baud", v, 32'(RST_DIV));
        repeat (5) @(negedge clk);
        chk("post_rst_idle", 32'(tx_o), 32'd1);

        // BAUD of 0 reads 1; mid-frame BAUD change hits the next frame only
        wr(A_BAUD, 32'd0);
        rd(A_BAUD, v); chk("baud_zero", v, 32'd1);
        wr(A_BAUD, 32'd3);
        wr(A_CTRL, 32'd1);
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        exp_b = {}; exp_d = {};
        exp_b.push_back(b1); exp_d.push_back(3);
        exp_b.push_back(b2); exp_d.push_back(8);
        wr(A_TX, {24'h0, b1});
        wr(A_TX, {24'h0, b2});
        wr(A_BAUD, 32'd8);
        trace("baudchg", 2, 1'b0);
        rd(A_BAUD, v); chk("baud_8", v, 32'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
